// File: rtl/reg_file_scoreboard_if.sv
// Decode/writeback bundle for the register file: read ports, issue request, writeback write,
// and the combinational read data / hazard / error returns.
interface reg_file_scoreboard_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
);
   logic [ADDR_W-1:0] read1_reg;
   logic              read1_use;
   logic [ADDR_W-1:0] read2_reg;
   logic              read2_use;
   logic              issue_en;
   logic [ADDR_W-1:0] issue_reg;
   logic              write_en;
   logic [ADDR_W-1:0] write_reg;
   logic [DATA_W-1:0] write_data;
   logic [DATA_W-1:0] read1_data;
   logic [DATA_W-1:0] read2_data;
   logic              stall;
   logic              err;

   modport master (
      output read1_reg, read1_use, read2_reg, read2_use,
             issue_en, issue_reg, write_en, write_reg, write_data,
      input  read1_data, read2_data, stall, err
   );

   modport slave (
      input  read1_reg, read1_use, read2_reg, read2_use,
             issue_en, issue_reg, write_en, write_reg, write_data,
      output read1_data, read2_data, stall, err
   );
endinterface

// File: rtl/reg_file_scoreboard.sv
// Architectural register file with write-to-read bypass and a per-register pending-write
// scoreboard that raises stall on RAW hazards and pulses err on counter over/underflow.
module reg_file_scoreboard #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3,
   parameter int PEND_W = 2
) (
   input logic                  clk,
   input logic                  rst,
   reg_file_scoreboard_if.slave bus
);
   localparam int unsigned NREG = 2 ** ADDR_W;
   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   logic [DATA_W-1:0] r_regs [NREG];
   logic [PEND_W-1:0] r_pend [NREG];
   logic              r_err;

   logic              w_ret1;
   logic              w_ret2;
   logic [PEND_W-1:0] w_left1;
   logic [PEND_W-1:0] w_left2;
   logic              w_stall;
   logic              w_iss;
   logic [NREG-1:0]   w_inc;
   logic [NREG-1:0]   w_dec;
   logic [PEND_W-1:0] w_pend_nxt [NREG];
   logic              w_err_nxt;

   // A writeback retiring the last pending write to a source clears its hazard this cycle.
   always_comb begin
      w_ret1  = bus.write_en && (bus.write_reg == bus.read1_reg);
      w_ret2  = bus.write_en && (bus.write_reg == bus.read2_reg);
      w_left1 = r_pend[bus.read1_reg] - PEND_W'(w_ret1);
      w_left2 = r_pend[bus.read2_reg] - PEND_W'(w_ret2);
      w_stall = (bus.read1_use && (w_left1 != '0)) || (bus.read2_use && (w_left2 != '0));
      w_iss   = bus.issue_en && !w_stall;
   end

   always_comb begin
      w_inc = '0;
      w_dec = '0;
      for (int unsigned r = 0; r < NREG; r++) begin
         w_inc[r] = w_iss && (bus.issue_reg == ADDR_W'(r));
         w_dec[r] = bus.write_en && (bus.write_reg == ADDR_W'(r));
      end
   end

   always_comb begin
      w_err_nxt = 1'b0;
      for (int unsigned r = 0; r < NREG; r++) begin
         w_pend_nxt[r] = r_pend[r];
         unique case ({w_inc[r], w_dec[r]})
            2'b10: begin
               if (r_pend[r] == PEND_MAX) w_err_nxt = 1'b1;
               else                       w_pend_nxt[r] = r_pend[r] + 1'b1;
            end
            2'b01: begin
               if (r_pend[r] == '0) w_err_nxt = 1'b1;
               else                 w_pend_nxt[r] = r_pend[r] - 1'b1;
            end
            default: w_pend_nxt[r] = r_pend[r];
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned r = 0; r < NREG; r++) begin
            r_regs[r] <= '0;
            r_pend[r] <= '0;
         end
         r_err <= 1'b0;
      end else begin
         if (bus.write_en) r_regs[bus.write_reg] <= bus.write_data;
         for (int unsigned r = 0; r < NREG; r++) r_pend[r] <= w_pend_nxt[r];
         r_err <= w_err_nxt;
      end
   end

   assign bus.read1_data = w_ret1 ? bus.write_data : r_regs[bus.read1_reg];
   assign bus.read2_data = w_ret2 ? bus.write_data : r_regs[bus.read2_reg];
   assign bus.stall      = w_stall;
   assign bus.err        = r_err;
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Scoreboard bench for reg_file_scoreboard: a behavioural model queues expected read data,
// stall and err for each driven cycle; they are popped and compared as the DUT responds.
module tb_reg_file_scoreboard;
   logic clk = 1'b0;
   logic rst = 1'b1;

   reg_file_scoreboard_if #(.DATA_W(16), .ADDR_W(3)) bus ();

   reg_file_scoreboard #(.DATA_W(16), .ADDR_W(3), .PEND_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] rd1;
      logic [15:0] rd2;
      logic        stall;
   } comb_t;

   comb_t       q_comb [$];
   logic        q_err  [$];
   logic [15:0] m_regs [8];
   logic [1:0]  m_pend [8];
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_regs[i] = '0;
         m_pend[i] = '0;
      end
      q_err.delete();
      q_comb.delete();
   endtask

   // Starts just after a rising edge; ends just after the next one.
   task automatic step(input bit ie, input int ir, input bit we, input int wr,
                       input logic [15:0] wd, input int r1, input bit u1,
                       input int r2, input bit u2);
      comb_t c, got;
      bit ret1, ret2, stl, iss, en;
      logic [1:0] l1, l2;
      bus.issue_en  = ie;  bus.issue_reg = 3'(ir);
      bus.write_en  = we;  bus.write_reg = 3'(wr);  bus.write_data = wd;
      bus.read1_reg = 3'(r1); bus.read1_use = u1;
      bus.read2_reg = 3'(r2); bus.read2_use = u2;
      #2;
      ret1 = we && (wr == r1);
      ret2 = we && (wr == r2);
      l1 = m_pend[r1] - 2'(ret1);
      l2 = m_pend[r2] - 2'(ret2);
      stl = (u1 && l1 != 0) || (u2 && l2 != 0);
      c.rd1 = ret1 ? wd : m_regs[r1];
      c.rd2 = ret2 ? wd : m_regs[r2];
      c.stall = stl;
      q_comb.push_back(c);
      got = q_comb.pop_front();
      chk("read1_data", bus.read1_data, got.rd1);
      chk("read2_data", bus.read2_data, got.rd2);
      chk("stall", bus.stall, got.stall);
      iss = ie && !stl;
      en = 1'b0;
      for (int r = 0; r < 8; r++) begin
         bit inc, dec;
         inc = iss && (ir == r);
         dec = we && (wr == r);
         if (inc && !dec) begin
            if (m_pend[r] == 2'd3) en = 1'b1;
            else m_pend[r] = m_pend[r] + 2'd1;
         end else if (dec && !inc) begin
            if (m_pend[r] == 2'd0) en = 1'b1;
            else m_pend[r] = m_pend[r] - 2'd1;
         end
      end
      if (we) m_regs[wr] = wd;
      q_err.push_back(en);
      @(posedge clk);
      #1;
      chk("err", bus.err, q_err.pop_front());
   endtask

   task automatic idle_read(input int r1, input bit u1, input int r2, input bit u2);
      step(1'b0, 0, 1'b0, 0, 16'h0, r1, u1, r2, u2);
   endtask

   initial begin
      bus.issue_en = 0; bus.issue_reg = 0; bus.write_en = 0; bus.write_reg = 0;
      bus.write_data = 0; bus.read1_reg = 0; bus.read1_use = 0;
      bus.read2_reg = 0; bus.read2_use = 0;
      model_reset();
      #12;
      for (int i = 0; i < 8; i++) begin
         bus.read1_reg = 3'(i);
         bus.read2_reg = 3'(7 - i);
         bus.read1_use = 1'b1;
         bus.read2_use = 1'b1;
         #1;
         chk("rst_read1", bus.read1_data, 16'h0);
         chk("rst_read2", bus.read2_data, 16'h0);
         chk("rst_stall", bus.stall, 1'b0);
         chk("rst_err", bus.err, 1'b0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Bypass then registered value.
      step(1'b0, 0, 1'b1, 3, 16'hBEEF, 3, 1'b1, 0, 1'b0);
      chk("bypass_direct", bus.read1_data, 16'hBEEF);
      idle_read(3, 1'b1, 3, 1'b1);

      // RAW hazard on R5 cleared by same-cycle writeback.
      step(1'b1, 5, 1'b0, 0, 16'h0, 0, 1'b0, 0, 1'b0);
      idle_read(0, 1'b0, 5, 1'b1);
      step(1'b0, 0, 1'b1, 5, 16'h1234, 0, 1'b0, 5, 1'b1);
      idle_read(0, 1'b0, 5, 1'b1);

      // Overflow then underflow on R7.
      for (int k = 0; k < 4; k++) step(1'b1, 7, 1'b0, 0, 16'h0, 0, 1'b0, 1, 1'b0);
      for (int k = 0; k < 4; k++) step(1'b0, 0, 1'b1, 7, 16'hA000 + 16'(k), 0, 1'b0, 1, 1'b0);
      idle_read(7, 1'b0, 7, 1'b0);

      // Stalled issue ignored; simultaneous issue+retire leaves count unchanged.
      step(1'b1, 2, 1'b0, 0, 16'h0, 0, 1'b0, 0, 1'b0);
      step(1'b1, 4, 1'b0, 0, 16'h0, 2, 1'b1, 0, 1'b0);
      idle_read(4, 1'b1, 0, 1'b0);
      step(1'b0, 0, 1'b1, 2, 16'h2222, 0, 1'b0, 0, 1'b0);
      step(1'b1, 4, 1'b0, 0, 16'h0, 0, 1'b0, 0, 1'b0);
      step(1'b1, 4, 1'b1, 4, 16'h4444, 0, 1'b0, 0, 1'b0);
      idle_read(4, 1'b1, 0, 1'b0);
      step(1'b0, 0, 1'b1, 4, 16'h4445, 4, 1'b1, 0, 1'b0);
      idle_read(4, 1'b1, 4, 1'b1);

      // Reset mid-run with R6 pending twice.
      step(1'b1, 6, 1'b0, 0, 16'h0, 0, 1'b0, 0, 1'b0);
      step(1'b1, 6, 1'b0, 0, 16'h0, 0, 1'b0, 0, 1'b0);
      bus.issue_en = 0; bus.write_en = 0;
      bus.read1_reg = 3'd6; bus.read1_use = 1'b1; bus.read2_use = 1'b0;
      #1;
      chk("pre_rst_stall", bus.stall, 1'b1);
      rst = 1'b1;
      #1;
      chk("mid_rst_stall", bus.stall, 1'b0);
      chk("mid_rst_data", bus.read1_data, 16'h0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle_read(6, 1'b1, 3, 1'b1);

      // Random traffic against the model.
      for (int k = 0; k < 80; k++) begin
         step(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 16'($urandom),
              int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
